// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: stream source / memory side.  slave: the loader itself.
interface imem_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_last_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;

  modport master (
    output byte_valid_i, byte_data_i, byte_last_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i, byte_last_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit
// words, writes them at consecutive word addresses from BASE_ADDR and holds
// the CPU in reset while a load is in progress.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: the stream ends with one
// extra word that must equal the XOR of all data words; it is never written.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  imem_loader_if.slave     bus,
  output logic             cpu_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_count_o
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        byte_idx_reg;
  logic [IDX_W-1:0]  word_idx_reg;
  logic [23:0]       shift_reg;
  logic [31:0]       mem_addr_reg;
  logic [31:0]       mem_data_reg;
  logic [CNT_W-1:0]  word_count_reg;
  logic              cpu_rst_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_reg;
`else
  logic              last_reg;
`endif

  logic        byte_fire;
  logic        start_ok;
  logic        word_last_slot;
  logic [31:0] word_assembled;

  assign byte_fire      = bus.byte_valid_i && (state_reg == ST_COLLECT);
  assign start_ok       = start_i && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                      (state_reg == ST_ERROR));
  // The word being written now occupies the last slot of the memory.
  assign word_last_slot = (word_idx_reg == IDX_W'(MAX_WORDS - 1));
  // Current byte completes the word in the least significant position.
  assign word_assembled = {shift_reg, bus.byte_data_i};

  assign bus.byte_ready_o = (state_reg == ST_COLLECT);
  assign bus.mem_we_o     = (state_reg == ST_WRITE);
  assign bus.mem_addr_o   = mem_addr_reg;
  assign bus.mem_data_o   = mem_data_reg;
  assign busy_o           = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE);
  assign done_o           = (state_reg == ST_DONE);
  assign err_o            = (state_reg == ST_ERROR);
  assign word_count_o     = word_count_reg;
  assign cpu_rst_o        = cpu_rst_reg;

  // Next-state logic of the load sequencer.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (byte_fire) begin
          if (byte_idx_reg == 2'd3) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            // A final word is the checksum: verify it instead of writing it.
            if (bus.byte_last_i)
              state_next = (word_assembled == csum_reg) ? ST_DONE : ST_ERROR;
            else
              state_next = ST_WRITE;
`else
            state_next = ST_WRITE;
`endif
          end else if (bus.byte_last_i) begin
            // Stream ended mid-word: drop the partial word.
            state_next = ST_ERROR;
          end
        end
      end
      ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_next = word_last_slot ? ST_ERROR : ST_COLLECT;
`else
        if (last_reg)
          state_next = ST_DONE;
        else if (word_last_slot)
          state_next = ST_ERROR;
        else
          state_next = ST_COLLECT;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; CPU reset is released only while idle or after success.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= ST_IDLE;
      cpu_rst_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cpu_rst_reg <= (state_next == ST_IDLE) || (state_next == ST_DONE);
    end
  end

  // Byte packing, write-port registers and word counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_idx_reg   <= 2'd0;
      word_idx_reg   <= '0;
      shift_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      word_count_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= '0;
`else
      last_reg       <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        byte_idx_reg   <= 2'd0;
        word_idx_reg   <= '0;
        shift_reg      <= '0;
        word_count_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_reg       <= '0;
`else
        last_reg       <= 1'b0;
`endif
      end
      if (byte_fire) begin
        shift_reg    <= word_assembled[23:0];
        byte_idx_reg <= byte_idx_reg + 2'd1;
        if (byte_idx_reg == 2'd3) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (!bus.byte_last_i) begin
            mem_addr_reg <= BASE_ADDR + (32'(word_idx_reg) << 2);
            mem_data_reg <= word_assembled;
            csum_reg     <= csum_reg ^ word_assembled;
          end
`else
          last_reg     <= bus.byte_last_i;
          mem_addr_reg <= BASE_ADDR + (32'(word_idx_reg) << 2);
          mem_data_reg <= word_assembled;
`endif
        end
      end
      if (state_reg == ST_WRITE) begin
        word_idx_reg   <= word_idx_reg + IDX_W'(1);
        word_count_reg <= word_count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader with a stream-level model.
module tb_imem_loader;
  localparam int MAXW  = 4;
  localparam int CNT_W = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             cpu_rst, busy, done, err;
  logic [CNT_W-1:0] wcnt;

  imem_loader_if bus();

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (MAXW),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .bus          (bus),
    .cpu_rst_o    (cpu_rst),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .word_count_o (wcnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      wr_addr_q.push_back(bus.mem_addr_o);
      wr_data_q.push_back(bus.mem_data_o);
    end
    if (busy) check_val("ready_vs_we", 32'(bus.byte_ready_o), 32'(!bus.mem_we_o));
    else      check_val("we_idle", 32'(bus.mem_we_o), 32'd0);
  end

  // Expected written words and outcome for a stream of len bytes with last on byte len.
  function automatic void model(input logic [7:0] b[$], input int len,
                                output logic [31:0] exp_w[$], output bit exp_done);
    int full;
    int nwr;
    logic [31:0] words[$];
    logic [31:0] x;
    full = len / 4;
    x = 32'd0;
    exp_w = {};
    words = {};
    for (int i = 0; i < full; i++)
      words.push_back({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
    exp_done = 1'b0;
    if (CS_EN) begin
      if ((len % 4) == 0) begin
        nwr = full - 1;
        if (nwr < MAXW) begin
          for (int i = 0; i < nwr; i++) x ^= words[i];
          exp_done = (x == words[full-1]);
        end
      end else begin
        nwr = full;
      end
    end else begin
      nwr = full;
      exp_done = ((len % 4) == 0);
    end
    if (nwr > MAXW) begin
      nwr = MAXW;
      exp_done = 1'b0;
    end
    for (int i = 0; i < nwr; i++) exp_w.push_back(words[i]);
  endfunction

  function automatic void build(input logic [31:0] w[$], input bit add_cs, input bit bad_cs,
                                output logic [7:0] b[$]);
    logic [31:0] x;
    logic [31:0] cur;
    x = 32'd0;
    b = {};
    foreach (w[i]) begin
      cur = w[i];
      x ^= cur;
      for (int k = 3; k >= 0; k--) b.push_back(cur[8*k +: 8]);
    end
    if (add_cs) begin
      if (bad_cs) x ^= 32'h0000_0001;
      for (int k = 3; k >= 0; k--) b.push_back(x[8*k +: 8]);
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    check_val({tag, "_we"},    32'(bus.mem_we_o), 32'd0);
    check_val({tag, "_addr"},  bus.mem_addr_o, 32'd0);
    check_val({tag, "_data"},  bus.mem_data_o, 32'd0);
    check_val({tag, "_busy"},  32'(busy), 32'd0);
    check_val({tag, "_done"},  32'(done), 32'd0);
    check_val({tag, "_err"},   32'(err), 32'd0);
    check_val({tag, "_count"}, 32'(wcnt), 32'd0);
    check_val({tag, "_cpurst"}, 32'(cpu_rst), 32'd0);
  endtask

  // Drive one byte; returns ok=0 if the loader stopped accepting (error or timeout).
  task automatic send_byte(input string name, input logic [7:0] d, input bit last, output bit ok);
    int t;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = d;
    bus.byte_last_i  = last;
    t = 0;
    while (!bus.byte_ready_o && !err && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = 1'b0;
    if (err) begin
      ok = 1'b0;
    end else if (!bus.byte_ready_o) begin
      check_val({name, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({name, "_cpu_held"}, 32'(cpu_rst), 32'd0);
      @(posedge clk);
      @(negedge clk);
      ok = 1'b1;
    end
    bus.byte_valid_i = 1'b0;
    bus.byte_last_i  = 1'b0;
  endtask

  task automatic run_load(input string name, input logic [7:0] b[$], input int len,
                          input int gap, input bit poke_start);
    logic [31:0] exp_w[$];
    bit exp_done;
    bit ok;
    int t;
    model(b, len, exp_w, exp_done);
    wr_addr_q = {};
    wr_data_q = {};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          if (err) break;
          start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
          @(negedge clk);
        end
      end
      start = 1'b0;
      if (err) break;
      send_byte(name, b[i], (i == len - 1), ok);
      if (!ok) break;
    end
    t = 0;
    while (!done && !err && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val({name, "_done"},   32'(done), 32'(exp_done));
    check_val({name, "_err"},    32'(err), 32'(!exp_done));
    check_val({name, "_count"},  32'(wcnt), 32'(exp_w.size()));
    check_val({name, "_cpurst"}, 32'(cpu_rst), 32'(exp_done));
    check_val({name, "_nwrites"}, 32'(wr_data_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < wr_data_q.size()) begin
        check_val({name, "_addr"}, wr_addr_q[i], 32'(4 * i));
        check_val({name, "_data"}, wr_data_q[i], exp_w[i]);
      end
    end
    $display("load %s: len=%0d gap=%0d writes=%0d done=%0d err=%0d count=%0d",
             name, len, gap, wr_data_q.size(), done, err, wcnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [7:0]  b[$];
    bit ok;
    int nw, len;

    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    bus.byte_last_i  = 1'b0;

    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("cpurst_before_edge", 32'(cpu_rst), 32'd0);
    @(negedge clk);
    check_val("cpurst_after_edge", 32'(cpu_rst), 32'd1);

    // Normal load
    w = '{32'h2008_0005, 32'h8C09_0004};
    build(w, CS_EN, 1'b0, b);
    run_load("normal", b, b.size(), 0, 1'b0);
    check_val("normal_w0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h2008_0005);
    check_val("normal_w1", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hDEAD_BEEF, 32'h8C09_0004);

    // Throttled stream with stray start pulses during the load
    run_load("throttled", b, b.size(), 3, 1'b1);

    // Short last on the third byte, then a good single-word load
    b = '{8'hAA, 8'hBB, 8'hCC};
    run_load("short", b, 3, 0, 1'b0);
    w = '{32'h1234_5678};
    build(w, CS_EN, 1'b0, b);
    run_load("retry", b, b.size(), 1, 1'b0);

    // Overflow: five words into a four-word memory
    w = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055};
    build(w, CS_EN, 1'b0, b);
    run_load("overflow", b, b.size(), 0, 1'b0);

    // Reset after word 0 and two bytes of word 1
    wr_addr_q = {};
    wr_data_q = {};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_byte("midreset", 8'(8'h10 + i), 1'b0, ok);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check_val("midreset_nwrites", 32'(wr_data_q.size()), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_val("midreset_nwrites_after", 32'(wr_data_q.size()), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    w = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
    build(w, CS_EN, 1'b0, b);
    run_load("reload", b, b.size(), 0, 1'b0);

    if (CS_EN) begin
      w = '{32'h2008_0005, 32'h8C09_0004, 32'hAC01_0001};
      build(w, 1'b0, 1'b0, b);
      run_load("cs_good", b, b.size(), 0, 1'b0);
      w = '{32'h2008_0005, 32'h8C09_0004, 32'hAC01_0000};
      build(w, 1'b0, 1'b0, b);
      run_load("cs_bad", b, b.size(), 0, 1'b0);
      w = '{32'h0000_0000};
      build(w, 1'b0, 1'b0, b);
      run_load("cs_empty", b, b.size(), 0, 1'b0);
    end

    // Randomised loads: random lengths, truncations, gaps and checksum errors
    for (int r = 0; r < 40; r++) begin
      nw = $urandom_range(1, MAXW + 1);
      w = {};
      for (int i = 0; i < nw; i++) w.push_back($urandom);
      build(w, CS_EN, ($urandom_range(0, 3) == 0), b);
      len = b.size();
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, b.size() - 1);
      run_load($sformatf("rand%0d", r), b, len, $urandom_range(0, 2), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
